// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the cpu_controller fetch path.
package cpu_pkg;

  localparam int PC_W_DEF    = 3;
  localparam int INSTR_W_DEF = 8;

  localparam logic [INSTR_W_DEF-1:0] HALT_OP = 8'hFF;
  localparam logic [INSTR_W_DEF-1:0] NOP_OP  = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_ADVANCE,
    S_HALT
  } fetch_state_t;

  // Opcode decode kept here so fetch and any future decoder agree on HALT.
  function automatic logic is_halt(input logic [INSTR_W_DEF-1:0] op);
    return op == HALT_OP;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch -> decoder handshake: instruction word with valid/ready flow control.
interface instruction_fetch_if #(
  parameter int INSTR_W = cpu_pkg::INSTR_W_DEF
);

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;

  modport master (output instr, output instr_valid, input  instr_ready);
  modport slave  (input  instr, input  instr_valid, output instr_ready);

endinterface

// File: rtl/instruction_fetch_mem.sv
// Small instruction store: one synchronous write port, one asynchronous read
// port, whole array cleared to NOP on reset.
module instr_mem
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [PC_W-1:0]    waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [PC_W-1:0]    raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << PC_W;

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Write port with synchronous clear of every entry.
  // NOTE: this array is reset because software relies on an empty program
  // reading as NOPs; that forces flops rather than a RAM macro, which is
  // acceptable only because the store is tiny.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INSTR_W'(NOP_OP);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: reads mem[pc], offers it to the decoder over valid/ready and
// pulses pc_inc after each accepted non-HALT instruction.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_W-1:0]     pc,
  output logic                pc_inc,
  input  logic                run,
  input  logic                load_en,
  input  logic [PC_W-1:0]     load_addr,
  input  logic [INSTR_W-1:0]  load_data,
  output logic                halted,
  instruction_fetch_if.master dec_if
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_we;

  instr_mem #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (pc),
    .rdata_o (mem_rdata)
  );

  // Next-state, instruction capture, load gating and Moore outputs.
  // NOTE: every signal gets its default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d            = state_q;
    instr_d            = instr_q;
    mem_we             = 1'b0;
    pc_inc             = 1'b0;
    halted             = 1'b0;
    dec_if.instr_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Loads are only safe while nothing is being fetched.
        mem_we = load_en;
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        instr_d = mem_rdata;
        state_d = S_VALID;
      end
      S_VALID: begin
        dec_if.instr_valid = 1'b1;
        if (dec_if.instr_ready) begin
          state_d = is_halt(INSTR_W_DEF'(instr_q)) ? S_HALT : S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        pc_inc  = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
        mem_we = load_en;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dec_if.instr = instr_q;

  // State and instruction registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a bench-side program counter.
module tb_instruction_fetch;
  import cpu_pkg::*;

  localparam int PC_W    = 3;
  localparam int INSTR_W = 8;

  typedef struct {
    logic [PC_W-1:0]    addr;
    logic [INSTR_W-1:0] data;
    logic [INSTR_W-1:0] exp_instr;
    int                 exp_gap;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               run;
  logic               load_en;
  logic [PC_W-1:0]    load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [PC_W-1:0]    pc;
  logic               pc_inc;
  logic               halted;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  instruction_fetch_if #(.INSTR_W(INSTR_W)) dec_if ();

  instruction_fetch #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .pc_inc    (pc_inc),
    .run       (run),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .halted    (halted),
    .dec_if    (dec_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for program_counter: pc_inc drives its enable.
  always @(posedge clk) begin
    if (rst)         pc <= '0;
    else if (pc_inc) pc <= pc + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance negedge by negedge until instr_valid is seen; bounded.
  task automatic wait_valid(input string name, output logic [INSTR_W-1:0] got, output int at);
    logic found;
    found = 1'b0;
    got   = '0;
    at    = -1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (dec_if.instr_valid === 1'b1) begin
        found = 1'b1;
        got   = dec_if.instr;
        at    = cyc;
      end
    end
    if (!found) check({name, " valid timeout"}, 32'd0, 32'd1);
  endtask

  task automatic load_word(input logic [PC_W-1:0] a, input logic [INSTR_W-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  initial begin
    vec_t               tbl [3];
    logic [INSTR_W-1:0] got;
    logic [INSTR_W-1:0] exp_seq [5];
    int                 at, prev, cnt;

    tbl[0] = '{addr: 3'd0, data: 8'h11, exp_instr: 8'h11, exp_gap: 2};
    tbl[1] = '{addr: 3'd1, data: 8'h22, exp_instr: 8'h22, exp_gap: 3};
    tbl[2] = '{addr: 3'd2, data: 8'h33, exp_instr: 8'h33, exp_gap: 3};

    rst = 1'b1; run = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    dec_if.instr_ready = 1'b0;

    // Reset and idle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst instr", dec_if.instr, 0);
    check("rst valid", dec_if.instr_valid, 0);
    check("rst pc_inc", pc_inc, 0);
    check("rst halted", halted, 0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (pc_inc) cnt++;
    end
    check("idle pc_inc count", cnt, 0);

    // Load and run from the table.
    foreach (tbl[i]) load_word(tbl[i].addr, tbl[i].data);
    run = 1'b1;
    dec_if.instr_ready = 1'b1;
    prev = cyc;
    foreach (tbl[i]) begin
      wait_valid("run", got, at);
      check($sformatf("run instr[%0d]", i), got, tbl[i].exp_instr);
      check($sformatf("run gap[%0d]", i), at - prev, tbl[i].exp_gap);
      prev = at;
      if (i == 2) run = 1'b0;
      @(negedge clk);
      check($sformatf("run pc_inc[%0d]", i), pc_inc, 1);
    end
    @(negedge clk);
    check("run pc after 3", pc, 3);
    dec_if.instr_ready = 1'b0;

    // Backpressure at pc=3.
    load_word(3'd3, 8'h44);
    run = 1'b1;
    wait_valid("bp", got, at);
    check("bp instr first", got, 8'h44);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp instr hold[%0d]", k), dec_if.instr, 8'h44);
      check($sformatf("bp valid hold[%0d]", k), dec_if.instr_valid, 1);
      check($sformatf("bp no pc_inc[%0d]", k), pc_inc, 0);
    end
    dec_if.instr_ready = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check("bp pc_inc after ready", pc_inc, 1);
    check("bp valid dropped", dec_if.instr_valid, 0);
    dec_if.instr_ready = 1'b0;
    @(negedge clk);

    // Load gating during VALID, then walk through the 7->0 wrap.
    run = 1'b1;
    wait_valid("gate", got, at);
    check("gate instr pc4", got, 8'h00);
    load_word(3'd5, 8'hAA);
    dec_if.instr_ready = 1'b1;
    exp_seq = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h00};
    for (int k = 0; k < 4; k++) begin
      wait_valid("wrap", got, at);
      check($sformatf("wrap pc[%0d]", k), pc, (k + 5) % 8);
      check($sformatf("wrap instr[%0d]", k), got, exp_seq[k]);
      if (k == 3) run = 1'b0;
    end

    // Reset during ADVANCE.
    @(negedge clk);
    check("mid pc_inc before rst", pc_inc, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid pc_inc cut", pc_inc, 0);
    check("mid valid", dec_if.instr_valid, 0);
    check("mid instr", dec_if.instr, 0);
    rst = 1'b0;
    run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_valid("clear", got, at);
      check($sformatf("clear mem[%0d]", k), got, 8'h00);
      if (k == 7) run = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("clear pc wrapped", pc, 0);

    // HALT at pc=7.
    load_word(3'd7, HALT_OP);
    run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_valid("halt", got, at);
      check($sformatf("halt walk instr[%0d]", k), got, (k == 7) ? HALT_OP : NOP_OP);
    end
    @(negedge clk);
    check("halt halted", halted, 1);
    check("halt valid", dec_if.instr_valid, 0);
    check("halt pc_inc", pc_inc, 0);
    load_word(3'd2, 8'h5A);
    check("halt load written", u_dut.u_mem.mem_q[2], 8'h5A);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (pc_inc) cnt++;
    end
    check("halt no pc_inc", cnt, 0);
    check("halt still halted", halted, 1);
    check("halt pc stays 7", pc, 7);

    rst = 1'b1;
    @(negedge clk);
    check("final rst halted", halted, 0);
    rst = 1'b0;
    run = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
